// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge engine.
package sobel_pkg;

    localparam logic MODE_L1  = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Sobel kernel weights: outer taps and centre tap of each 1-2-1 row/column
    localparam int K_SIDE   = 1;
    localparam int K_CENTRE = 2;

    // Wide enough for |Gx|+|Gy| = 2*4*(2^data_w-1) without saturation
    function automatic int mag_width(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-line pixel delay: each slot is read one accept ahead of being overwritten,
// so dout always holds the pixel accepted exactly DEPTH accepts earlier.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_reg;
    logic [AW-1:0]     ptr_reg;
    logic [AW-1:0]     ptr_next;

    assign ptr_next = (ptr_reg == AW'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;
    assign dout     = dout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (en) begin
            ptr_reg <= ptr_next;
        end
    end

    // Contents are don't-care after reset: the first two lines never form a window
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_reg] <= din;
            dout_reg     <= mem[ptr_next];
        end
    end

endmodule

// File: rtl/sobel_stream_pipe.sv
// Streaming 3x3 Sobel gradient engine with valid/ready flow control, raster
// position tracking, frame resync on s_sof and a two-stage magnitude pipeline.
module sobel_stream_pipe
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int MAG_W  = mag_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic [MAG_W-1:0]  thresh,
    input  logic              mode,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [MAG_W-1:0]  m_mag,
    output logic              m_edge,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_last,
    output logic              frame_err
);
    localparam int GW = DATA_W + 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef logic signed [GW-1:0] grad_t;
    typedef logic [GW-2:0]        abs_t;

    function automatic grad_t wsum(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] c);
        return grad_t'(K_SIDE) * grad_t'(a) + grad_t'(K_CENTRE) * grad_t'(b)
             + grad_t'(K_SIDE) * grad_t'(c);
    endfunction

    function automatic abs_t mag_abs(input grad_t g);
        return abs_t'(g[GW-1] ? -g : g);
    endfunction

    logic stall, accept;
    assign stall   = m_valid && !m_ready;
    assign s_ready = !stall;
    assign accept  = s_valid && s_ready;

    // ---------------- raster position ----------------
    logic [CW-1:0] col_reg, eff_col;
    logic [RW-1:0] row_reg, eff_row;
    logic          resync, win_valid, at_sof, at_eol, at_last;
    logic          frame_err_reg;

    // An s_sof pixel is always position (0,0), whatever the counters said
    always_comb begin
        resync    = s_sof && ((col_reg != '0) || (row_reg != '0));
        eff_col   = s_sof ? '0 : col_reg;
        eff_row   = s_sof ? '0 : row_reg;
        win_valid = (eff_row >= RW'(2)) && (eff_col >= CW'(2));
        at_sof    = (eff_row == RW'(2)) && (eff_col == CW'(2));
        at_eol    = (eff_col == CW'(IMG_W - 1));
        at_last   = at_eol && (eff_row == RW'(IMG_H - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg       <= '0;
            row_reg       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= accept && resync;
            if (accept) begin
                if (at_eol) begin
                    col_reg <= '0;
                    row_reg <= (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + 1'b1;
                end else begin
                    col_reg <= eff_col + 1'b1;
                    row_reg <= eff_row;
                end
            end
        end
    end

    assign frame_err = frame_err_reg;

    // ---------------- line buffers and 3x3 window ----------------
    logic [DATA_W-1:0] lb0_out, lb1_out;
    logic [DATA_W-1:0] col_l [3];
    logic [DATA_W-1:0] col_m [3];
    logic [DATA_W-1:0] col_r [3];

    sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk(clk), .rst(rst), .en(accept), .din(s_data),  .dout(lb0_out)
    );
    sobel_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .rst(rst), .en(accept), .din(lb0_out), .dout(lb1_out)
    );

    // Right column is live so the window including the newest pixel is used at accept
    assign col_r[0] = lb1_out;
    assign col_r[1] = lb0_out;
    assign col_r[2] = s_data;

    for (genvar gi = 0; gi < 3; gi++) begin : g_win
        logic [DATA_W-1:0] left_reg, mid_reg;
        always_ff @(posedge clk) begin
            if (accept) begin
                left_reg <= mid_reg;
                mid_reg  <= col_r[gi];
            end
        end
        assign col_l[gi] = left_reg;
        assign col_m[gi] = mid_reg;
    end

    grad_t gx, gy;
    assign gx = wsum(col_r[0], col_r[1], col_r[2]) - wsum(col_l[0], col_l[1], col_l[2]);
    assign gy = wsum(col_l[2], col_m[2], col_r[2]) - wsum(col_l[0], col_m[0], col_r[0]);

    // ---------------- stage A: absolute gradients ----------------
    logic valid_a_reg, sof_a_reg, eol_a_reg, last_a_reg;
    abs_t ax_a_reg, ay_a_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_a_reg <= 1'b0;
        end else if (!stall) begin
            valid_a_reg <= accept && win_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            ax_a_reg   <= mag_abs(gx);
            ay_a_reg   <= mag_abs(gy);
            sof_a_reg  <= at_sof;
            eol_a_reg  <= at_eol;
            last_a_reg <= at_last;
        end
    end

    // ---------------- stage B: magnitude and threshold ----------------
    logic [MAG_W-1:0] mag_sel;
    always_comb begin
        if (mode == MODE_MAX) begin
            mag_sel = (ax_a_reg >= ay_a_reg) ? MAG_W'(ax_a_reg) : MAG_W'(ay_a_reg);
        end else begin
            mag_sel = MAG_W'(ax_a_reg) + MAG_W'(ay_a_reg);
        end
    end

    logic             valid_b_reg, edge_b_reg, sof_b_reg, eol_b_reg, last_b_reg;
    logic [MAG_W-1:0] mag_b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_b_reg <= 1'b0;
            mag_b_reg   <= '0;
            edge_b_reg  <= 1'b0;
            sof_b_reg   <= 1'b0;
            eol_b_reg   <= 1'b0;
            last_b_reg  <= 1'b0;
        end else if (!stall) begin
            valid_b_reg <= valid_a_reg;
            mag_b_reg   <= mag_sel;
            edge_b_reg  <= valid_a_reg && (mag_sel >= thresh);
            sof_b_reg   <= valid_a_reg && sof_a_reg;
            eol_b_reg   <= valid_a_reg && eol_a_reg;
            last_b_reg  <= valid_a_reg && last_a_reg;
        end
    end

    assign m_valid = valid_b_reg;
    assign m_mag   = mag_b_reg;
    assign m_edge  = edge_b_reg;
    assign m_sof   = sof_b_reg;
    assign m_eol   = eol_b_reg;
    assign m_last  = last_b_reg;

endmodule

// File: tb/tb_sobel_stream_pipe.sv
// Directed bench for sobel_stream_pipe on an 8x6 image.
module tb_sobel_stream_pipe;
    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int MAG_W  = 11;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NOUT   = (IMG_W - 2) * (IMG_H - 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sof;
    logic [MAG_W-1:0]  thresh;
    logic              mode;
    logic              m_valid;
    logic              m_ready;
    logic [MAG_W-1:0]  m_mag;
    logic              m_edge;
    logic              m_sof;
    logic              m_eol;
    logic              m_last;
    logic              frame_err;

    always #5 clk = ~clk;

    sobel_stream_pipe #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .MAG_W(MAG_W)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .thresh(thresh), .mode(mode), .m_valid(m_valid), .m_ready(m_ready),
        .m_mag(m_mag), .m_edge(m_edge), .m_sof(m_sof), .m_eol(m_eol), .m_last(m_last),
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic             edge_b;
        logic             sof;
        logic             eol;
        logic             last;
    } out_t;

    out_t              out_q[$];
    out_t              ref_q[$];
    int                err_cycles = 0;
    int                passed = 0;
    int                total  = 0;
    logic [DATA_W-1:0] frame_px [NPIX];

    // Observe transfers and frame_err away from the active edge
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            out_q.push_back('{m_mag, m_edge, m_sof, m_eol, m_last});
            $display("out #%0d mag=%0d edge=%0b sof=%0b eol=%0b last=%0b",
                     out_q.size() - 1, m_mag, m_edge, m_sof, m_eol, m_last);
        end
        if (frame_err) err_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        out_q.delete();
        err_cycles = 0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Stream n pixels of frame_px, raising s_sof on index sof_idx
    task automatic drive_frame(input int n, input int sof_idx);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 1000) begin
            s_valid = 1'b1;
            s_data  = frame_px[i];
            s_sof   = (i == sof_idx);
            @(negedge clk);
            if (s_ready) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        total++;
        if (i < n) $display("FAIL drive_timeout: accepted %0d pixels, required %0d", i, n);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
        thresh = MAG_W'(500); mode = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b want 0", m_valid); else passed++;
        total++; if (m_mag !== '0) $display("FAIL reset_m_mag: got %0d want 0", m_mag); else passed++;
        total++; if (m_edge !== 1'b0) $display("FAIL reset_m_edge: got %0b want 0", m_edge); else passed++;
        total++; if (m_sof !== 1'b0) $display("FAIL reset_m_sof: got %0b want 0", m_sof); else passed++;
        total++; if (m_eol !== 1'b0) $display("FAIL reset_m_eol: got %0b want 0", m_eol); else passed++;
        total++; if (m_last !== 1'b0) $display("FAIL reset_m_last: got %0b want 0", m_last); else passed++;
        total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %0b want 0", frame_err); else passed++;
        total++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %0b want 1", s_ready); else passed++;
    endtask

    task automatic test_flat();
        for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd100;
        mode = 1'b0;
        clear_obs();
        drive_frame(NPIX, 0);
        drain();
        total++;
        if (out_q.size() != NOUT) $display("FAIL flat_count: got %0d want %0d", out_q.size(), NOUT);
        else passed++;
        for (int k = 0; k < out_q.size() && k < NOUT; k++) begin
            total++;
            if (out_q[k].mag !== '0 || out_q[k].edge_b !== 1'b0)
                $display("FAIL flat_mag[%0d]: got mag=%0d edge=%0b want 0/0", k, out_q[k].mag, out_q[k].edge_b);
            else passed++;
            total++;
            if (out_q[k].sof !== (k == 0) || out_q[k].eol !== (k % 6 == 5) || out_q[k].last !== (k == NOUT - 1))
                $display("FAIL flat_markers[%0d]: got sof/eol/last=%0b%0b%0b want %0b%0b%0b", k,
                         out_q[k].sof, out_q[k].eol, out_q[k].last, k == 0, k % 6 == 5, k == NOUT - 1);
            else passed++;
        end
    endtask

    task automatic test_vstep();
        for (int i = 0; i < NPIX; i++) frame_px[i] = ((i % IMG_W) < 4) ? 8'd0 : 8'd200;
        for (int m = 0; m < 2; m++) begin
            mode = m[0];
            clear_obs();
            drive_frame(NPIX, 0);
            drain();
            total++;
            if (out_q.size() != NOUT) $display("FAIL vstep_count mode=%0d: got %0d want %0d", m, out_q.size(), NOUT);
            else passed++;
            for (int k = 0; k < out_q.size() && k < NOUT; k++) begin
                logic [MAG_W-1:0] exp_mag;
                exp_mag = (k % 6 == 2 || k % 6 == 3) ? MAG_W'(800) : MAG_W'(0);
                total++;
                if (out_q[k].mag !== exp_mag || out_q[k].edge_b !== (exp_mag != 0))
                    $display("FAIL vstep[%0d] mode=%0d: got mag=%0d edge=%0b want mag=%0d edge=%0b",
                             k, m, out_q[k].mag, out_q[k].edge_b, exp_mag, exp_mag != 0);
                else passed++;
            end
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd0;
        frame_px[2 * IMG_W + 2] = 8'd255;
        for (int m = 0; m < 2; m++) begin
            logic [MAG_W-1:0] exp_mag;
            logic             exp_edge;
            exp_mag  = (m == 0) ? MAG_W'(510) : MAG_W'(255);
            exp_edge = (m == 0);
            mode = m[0];
            clear_obs();
            drive_frame(NPIX, 0);
            drain();
            total++;
            if (out_q.size() == 0) $display("FAIL single_none mode=%0d: got 0 outputs want %0d", m, NOUT);
            else if (out_q[0].mag !== exp_mag || out_q[0].edge_b !== exp_edge || out_q[0].sof !== 1'b1)
                $display("FAIL single mode=%0d: got mag=%0d edge=%0b sof=%0b want mag=%0d edge=%0b sof=1",
                         m, out_q[0].mag, out_q[0].edge_b, out_q[0].sof, exp_mag, exp_edge);
            else passed++;
        end
        mode = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < NPIX; i++) frame_px[i] = DATA_W'($urandom_range(0, 255));
        mode = 1'b0;
        clear_obs();
        drive_frame(NPIX, 0);
        drain();
        ref_q = out_q;
        total++;
        if (ref_q.size() != NOUT) $display("FAIL stall_ref_count: got %0d want %0d", ref_q.size(), NOUT);
        else passed++;
        clear_obs();
        fork
            drive_frame(NPIX, 0);
            begin
                logic [MAG_W+4:0] snap;
                int g = 0;
                repeat (22) @(posedge clk);
                #1;
                m_ready = 1'b0;
                @(negedge clk);
                while (!m_valid && g < 20) begin
                    @(negedge clk);
                    g++;
                end
                total++;
                if (!m_valid) $display("FAIL stall_wait: got m_valid=0 want 1 within 20 cycles");
                else passed++;
                snap = {m_valid, m_mag, m_edge, m_sof, m_eol, m_last};
                for (int c = 0; c < 5; c++) begin
                    total++;
                    if (s_ready !== 1'b0) $display("FAIL stall_s_ready cyc %0d: got %0b want 0", c, s_ready);
                    else passed++;
                    total++;
                    if ({m_valid, m_mag, m_edge, m_sof, m_eol, m_last} !== snap)
                        $display("FAIL stall_hold cyc %0d: got %h want %h", c,
                                 {m_valid, m_mag, m_edge, m_sof, m_eol, m_last}, snap);
                    else passed++;
                    if (c < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain();
        total++;
        if (out_q.size() != NOUT) $display("FAIL stall_count: got %0d want %0d", out_q.size(), NOUT);
        else passed++;
        for (int k = 0; k < out_q.size() && k < ref_q.size(); k++) begin
            total++;
            if (out_q[k] !== ref_q[k]) $display("FAIL stall_seq[%0d]: got %h want %h", k, out_q[k], ref_q[k]);
            else passed++;
        end
    endtask

    task automatic test_sof_resync();
        int nonzero = 0;
        for (int i = 0; i < 20; i++) frame_px[i] = DATA_W'(i * 5 + 3);
        clear_obs();
        drive_frame(20, 0);
        for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd50;
        drive_frame(NPIX, 0);
        drain();
        total++;
        if (err_cycles != 1) $display("FAIL sof_err_pulse: got %0d cycles want 1", err_cycles);
        else passed++;
        total++;
        if (out_q.size() != NOUT + 2) $display("FAIL sof_count: got %0d want %0d", out_q.size(), NOUT + 2);
        else passed++;
        if (out_q.size() == NOUT + 2) begin
            total++;
            if (out_q[2].sof !== 1'b1 || out_q[1].sof !== 1'b0)
                $display("FAIL sof_first: got sof[1]=%0b sof[2]=%0b want 0/1", out_q[1].sof, out_q[2].sof);
            else passed++;
            total++;
            if (out_q[NOUT + 1].last !== 1'b1) $display("FAIL sof_last: got %0b want 1", out_q[NOUT + 1].last);
            else passed++;
            for (int k = 2; k < NOUT + 2; k++) if (out_q[k].mag != 0) nonzero++;
            total++;
            if (nonzero != 0) $display("FAIL sof_align: got %0d nonzero magnitudes want 0", nonzero);
            else passed++;
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < NPIX; i++) frame_px[i] = DATA_W'(i * 3);
        clear_obs();
        drive_frame(21, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (m_valid !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL rst_mid_clear: got m_valid=%0b frame_err=%0b want 0/0", m_valid, frame_err);
        else passed++;
        clear_obs();
        for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd77;
        drive_frame(NPIX, 0);
        drain();
        total++;
        if (out_q.size() != NOUT) $display("FAIL rst_mid_count: got %0d want %0d", out_q.size(), NOUT);
        else passed++;
        total++;
        if (err_cycles != 0) $display("FAIL rst_mid_err: got %0d cycles want 0", err_cycles);
        else passed++;
        if (out_q.size() == NOUT) begin
            total++;
            if (out_q[0].sof !== 1'b1 || out_q[NOUT - 1].last !== 1'b1)
                $display("FAIL rst_mid_markers: got sof=%0b last=%0b want 1/1", out_q[0].sof, out_q[NOUT - 1].last);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vstep();
        test_single();
        test_stall();
        test_sof_resync();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
